// File: rtl/sc_pkg.sv
// Shared definitions for the register-file write arbiter.
// Requester ids, arbiter state encoding and default widths.
package sc_pkg;

    localparam int DATA_W_D = 8;
    localparam int ADDR_W_D = 3;

    localparam logic [1:0] REQ_ALU  = 2'd0;
    localparam logic [1:0] REQ_LOAD = 2'd1;
    localparam logic [1:0] REQ_DBG  = 2'd2;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x >= 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick3.sv
// Combinational round-robin pick among three requesters.
// Search starts at ptr and wraps 0->1->2->0.
module rr_pick3
    import sc_pkg::*;
(
    input  logic [2:0] valid,
    input  logic [1:0] ptr,
    output logic [2:0] grant,
    output logic [1:0] winner
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        grant  = '0;
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int k = 0; k < 3; k++) begin
            if (!found && valid[idx]) begin
                found      = 1'b1;
                winner     = idx;
                grant[idx] = 1'b1;
            end
            idx = inc3(idx);
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter with bounded lock for the single
// register-file write port; registered write outputs.
module regfile_write_arbiter
    import sc_pkg::*;
#(
    parameter int DATA_W    = DATA_W_D,
    parameter int ADDR_W    = ADDR_W_D,
    parameter int MAX_BURST = 4,
    parameter int ZERO_RO   = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              hold,
    input  logic [2:0]        req_valid,
    input  logic [2:0]        req_lock,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_data2,
    output logic [2:0]        req_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [1:0]        grant_id,
    output logic              locked
);

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    arb_state_t  state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]  owner_q, owner_d;
    logic [3:0]  burst_q, burst_d;

    logic [2:0]        pick_grant;
    logic [1:0]        pick_win;
    logic [1:0]        win;
    logic              xfer;
    logic              drop;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_pick3 u_pick (
        .valid  (req_valid),
        .ptr    (rr_ptr_q),
        .grant  (pick_grant),
        .winner (pick_win)
    );

    // clear gates ready so an async reset kills the handshake at once
    always_comb begin
        req_ready = '0;
        win       = pick_win;
        if (state_q == LOCKED)
            win = owner_q;
        if (clear && !hold) begin
            if (state_q == ARB)
                req_ready = pick_grant;
            else if (req_valid[owner_q])
                req_ready = 3'b001 << owner_q;
        end
    end

    assign xfer   = |req_ready;
    assign locked = (state_q == LOCKED);

    always_comb begin
        sel_addr = req_addr2;
        sel_data = req_data2;
        unique case (win)
            REQ_ALU: begin
                sel_addr = req_addr0;
                sel_data = req_data0;
            end
            REQ_LOAD: begin
                sel_addr = req_addr1;
                sel_data = req_data1;
            end
            default: begin
                sel_addr = req_addr2;
                sel_data = req_data2;
            end
        endcase
    end

    assign drop = (ZERO_RO != 0) && (sel_addr == '0);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        burst_d  = burst_q;
        if (xfer)
            rr_ptr_d = inc3(win);
        unique case (state_q)
            ARB: begin
                if (xfer && req_lock[win]) begin
                    state_d = LOCKED;
                    owner_d = win;
                    burst_d = 4'd1;
                end
            end
            LOCKED: begin
                if (!hold) begin
                    if (!req_valid[owner_q]) begin
                        state_d = ARB;
                    end else begin
                        burst_d = burst_q + 4'd1;
                        if (!req_lock[owner_q] || burst_d == MAX_B)
                            state_d = ARB;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            burst_q  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            grant_id <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            burst_q  <= burst_d;
            wr_en    <= xfer && !drop;
            if (xfer && !drop) begin
                wr_addr  <= sel_addr;
                wr_data  <= sel_data;
                grant_id <= win;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed table, corner
// sequences and random traffic against a reference model.
module tb_regfile_write_arbiter;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          clear = 1'b0;
    logic          hold = 1'b0;
    logic [2:0]    req_valid = '0;
    logic [2:0]    req_lock = '0;
    logic [AW-1:0] ra [3];
    logic [DW-1:0] rd [3];
    logic [2:0]    req_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    grant_id;
    logic          locked;

    regfile_write_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB), .ZERO_RO(1)
    ) dut (
        .clk(clk), .clear(clear), .hold(hold),
        .req_valid(req_valid), .req_lock(req_lock),
        .req_addr0(ra[0]), .req_addr1(ra[1]), .req_addr2(ra[2]),
        .req_data0(rd[0]), .req_data1(rd[1]), .req_data2(rd[2]),
        .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .grant_id(grant_id), .locked(locked)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // reference model: plain integers, one write slot
    bit m_locked;
    int m_owner, m_ptr, m_cnt;
    bit e_en;
    int e_addr, e_data, e_gid;

    typedef struct {
        logic [2:0] v;
        logic [2:0] l;
        logic       h;
        logic [2:0] rdy;
        logic       en;
        logic [1:0] gid;
        logic       lk;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     n, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] m_ready();
        if (!clear || hold) return 3'b000;
        if (m_locked)
            return req_valid[m_owner] ? 3'(1 << m_owner) : 3'b000;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (m_ptr + k) % 3;
            if (req_valid[i]) return 3'(1 << i);
        end
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        e_en = 0; e_addr = 0; e_data = 0; e_gid = 0;
    endtask

    task automatic model_update();
        logic [2:0] r;
        int w;
        r = m_ready();
        if (r != 3'b000) begin
            w = r[0] ? 0 : (r[1] ? 1 : 2);
            e_en = (ra[w] != 0);
            if (e_en) begin
                e_addr = int'(ra[w]);
                e_data = int'(rd[w]);
                e_gid  = w;
            end
            m_ptr = (w + 1) % 3;
            if (!m_locked) begin
                if (req_lock[w]) begin
                    m_locked = 1; m_owner = w; m_cnt = 1;
                end
            end else begin
                m_cnt++;
                if (!req_lock[w] || m_cnt == MB) m_locked = 0;
            end
        end else begin
            e_en = 0;
            if (m_locked && clear && !hold && !req_valid[m_owner])
                m_locked = 0;
        end
    endtask

    task automatic model_check();
        chk("m_ready", 32'(req_ready), 32'(m_ready()));
        chk("m_wr_en", 32'(wr_en), 32'(e_en));
        chk("m_locked", 32'(locked), 32'(m_locked));
        chk("m_wr_addr", 32'(wr_addr), 32'(e_addr));
        chk("m_wr_data", 32'(wr_data), 32'(e_data));
        chk("m_grant_id", 32'(grant_id), 32'(e_gid));
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic at_pos();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        req_valid = 3'b111;
        req_lock = '0;
        hold = 0;
        clear = 0;
        model_reset();
        #2;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_addr", 32'(wr_addr), 0);
        chk("rst_data", 32'(wr_data), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_locked", 32'(locked), 0);
        req_valid = '0;
        @(negedge clk);
        clear = 1;
        at_pos();
    endtask

    initial begin
        tbl[0]  = '{3'b111, 3'b000, 0, 3'b001, 0, 2'd0, 0};
        tbl[1]  = '{3'b111, 3'b000, 0, 3'b010, 1, 2'd0, 0};
        tbl[2]  = '{3'b111, 3'b000, 0, 3'b100, 1, 2'd1, 0};
        tbl[3]  = '{3'b111, 3'b000, 0, 3'b001, 1, 2'd2, 0};
        tbl[4]  = '{3'b111, 3'b000, 0, 3'b010, 1, 2'd0, 0};
        tbl[5]  = '{3'b111, 3'b000, 0, 3'b100, 1, 2'd1, 0};
        tbl[6]  = '{3'b000, 3'b000, 0, 3'b000, 1, 2'd2, 0};
        tbl[7]  = '{3'b010, 3'b010, 0, 3'b010, 0, 2'd0, 0};
        tbl[8]  = '{3'b111, 3'b010, 0, 3'b010, 1, 2'd1, 1};
        tbl[9]  = '{3'b111, 3'b010, 0, 3'b010, 1, 2'd1, 1};
        tbl[10] = '{3'b111, 3'b010, 0, 3'b010, 1, 2'd1, 1};
        tbl[11] = '{3'b111, 3'b010, 0, 3'b100, 1, 2'd1, 0};
        tbl[12] = '{3'b111, 3'b010, 0, 3'b001, 1, 2'd2, 0};
        tbl[13] = '{3'b111, 3'b000, 0, 3'b010, 1, 2'd0, 0};
        tbl[14] = '{3'b000, 3'b000, 0, 3'b000, 1, 2'd1, 0};

        ra[0] = 3'd5; ra[1] = 3'd2; ra[2] = 3'd3;
        rd[0] = 8'hA5; rd[1] = 8'h22; rd[2] = 8'h33;
        #3;
        do_reset();

        // single write, one-cycle latency
        req_valid = 3'b001;
        at_neg();
        chk("sw_ready", 32'(req_ready), 32'b001);
        at_pos();
        req_valid = 3'b000;
        at_neg();
        chk("sw_en", 32'(wr_en), 1);
        chk("sw_addr", 32'(wr_addr), 5);
        chk("sw_data", 32'(wr_data), 32'hA5);
        chk("sw_gid", 32'(grant_id), 0);
        at_pos();
        at_neg();
        chk("sw_en_off", 32'(wr_en), 0);
        at_pos();

        // round robin and lock burst table from reset
        ra[0] = 3'd1; rd[0] = 8'h11;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            req_valid = tbl[i].v;
            req_lock  = tbl[i].l;
            hold      = tbl[i].h;
            at_neg();
            chk($sformatf("t%0d_ready", i), 32'(req_ready),
                32'(tbl[i].rdy));
            chk($sformatf("t%0d_en", i), 32'(wr_en), 32'(tbl[i].en));
            chk($sformatf("t%0d_locked", i), 32'(locked),
                32'(tbl[i].lk));
            if (tbl[i].en)
                chk($sformatf("t%0d_gid", i), 32'(grant_id),
                    32'(tbl[i].gid));
            at_pos();
        end

        // write to register 0 is accepted but dropped
        req_lock = '0;
        ra[2] = 3'd0; rd[2] = 8'hFF;
        req_valid = 3'b100;
        at_neg();
        chk("z_ready", 32'(req_ready), 32'b100);
        at_pos();
        req_valid = 3'b111;
        at_neg();
        chk("z_en", 32'(wr_en), 0);
        chk("z_addr_kept", 32'(wr_addr), 2);
        chk("z_ptr", 32'(req_ready), 32'b001);
        at_pos();

        // hold freezes arbitration
        req_valid = 3'b000;
        at_neg();
        at_pos();
        req_valid = 3'b111;
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("h_ready", 32'(req_ready), 0);
            chk("h_en", 32'(wr_en), 0);
            at_pos();
        end
        hold = 0;
        at_neg();
        chk("h_resume", 32'(req_ready), 32'b010);
        at_pos();

        // async reset while locked
        ra[2] = 3'd3; rd[2] = 8'h33;
        req_valid = 3'b001;
        req_lock = 3'b001;
        at_neg();
        at_pos();
        at_neg();
        chk("ar_locked_pre", 32'(locked), 1);
        at_pos();
        #2;
        clear = 0;
        model_reset();
        #1;
        chk("ar_locked", 32'(locked), 0);
        chk("ar_en", 32'(wr_en), 0);
        chk("ar_ready", 32'(req_ready), 0);
        @(negedge clk);
        clear = 1;
        req_valid = 3'b111;
        req_lock = 3'b000;
        #1;
        chk("ar_restart", 32'(req_ready), 32'b001);
        model_check();
        at_pos();

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            req_valid = 3'($urandom_range(0, 7));
            req_lock  = 3'($urandom_range(0, 7));
            hold      = ($urandom_range(0, 7) == 0);
            for (int j = 0; j < 3; j++) begin
                ra[j] = AW'($urandom);
                rd[j] = DW'($urandom);
            end
            at_neg();
            at_pos();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
